// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared encodings and helpers for the MIPS pipeline controller.
// Latency: n/a (constants and a constant-evaluable helper only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    // FSM state encodings (also the o_state output values).
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Pipeline register indices within o_stage_en / o_flush.
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

    // Default hazard behaviour.
    localparam int DEF_LOAD_USE_CYCLES = 1;
    localparam int DEF_BRANCH_FLUSH    = 3;
    localparam int DEF_JUMP_FLUSH      = 2;

    // Widest pipeline the mask helper can describe.
    localparam int MAX_STAGES = 32;

    // Mask with bits 1..depth set: the registers behind a redirect that
    // hold wrong-path instructions. Bit 0 (PC) is never flushed.
    function automatic logic [MAX_STAGES-1:0] flush_span(input int depth);
        logic [MAX_STAGES-1:0] m;
        m = '0;
        for (int i = 1; i < MAX_STAGES; i++) begin
            if (i <= depth) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Purpose: flags a load in EX whose destination is read by the instruction in ID.
// Latency: combinational, zero cycles.
// Backpressure: none; pure comparator.
// Ports: i_id_rs/i_id_rt/i_id_uses_rt describe the ID reader, i_ex_rt/
//        i_ex_mem_read the EX load, o_load_use is the hazard flag.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REGS = 5
) (
    input  logic [NB_REGS-1:0] i_id_rs,
    input  logic [NB_REGS-1:0] i_id_rt,
    input  logic               i_id_uses_rt,
    input  logic [NB_REGS-1:0] i_ex_rt,
    input  logic               i_ex_mem_read,
    output logic               o_load_use
);

    logic rs_hit;
    logic rt_hit;

    // Register 0 is hard-wired zero, so a load into it never creates a hazard.
    assign rs_hit     = (i_ex_rt == i_id_rs);
    assign rt_hit     = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: per-register enable/flush generation, load-use stall, branch/jump
//          squash, single-step advance, halt drain and performance counters.
// Latency: enables/flushes combinational from hazard inputs; FSM and counters registered.
// Backpressure: advance=0 (step mode without i_step) freezes enables, flushes, FSM and counters.
// Ports: i_clk, i_reset (async active-low); debug step inputs; ID/EX hazard
//        operands; redirect and halt requests; o_stage_en/o_flush per
//        pipeline register; o_state/o_halted status; cycle and stall counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int N_STAGES        = 5,
    parameter int NB_REGS         = 5,
    parameter int LOAD_USE_CYCLES = DEF_LOAD_USE_CYCLES,
    parameter int BRANCH_FLUSH    = DEF_BRANCH_FLUSH,
    parameter int JUMP_FLUSH      = DEF_JUMP_FLUSH,
    parameter int NB_CNT          = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_debug_mode,
    input  logic                i_step,
    input  logic [NB_REGS-1:0]  i_id_rs,
    input  logic [NB_REGS-1:0]  i_id_rt,
    input  logic                i_id_uses_rt,
    input  logic [NB_REGS-1:0]  i_ex_rt,
    input  logic                i_ex_mem_read,
    input  logic                i_branch_taken,
    input  logic                i_jump,
    input  logic                i_id_halt,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic [N_STAGES-1:0] o_flush,
    output logic [1:0]          o_state,
    output logic                o_halted,
    output logic [NB_CNT-1:0]   o_cycle_count,
    output logic [NB_CNT-1:0]   o_stall_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (N_STAGES < STG_EX_MEM + 1 || N_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("pipeline_ctrl: N_STAGES must be in 4..32");
    end
    if (BRANCH_FLUSH >= N_STAGES || JUMP_FLUSH >= N_STAGES) begin : g_bad_flush
        $error("pipeline_ctrl: flush depths must be below N_STAGES");
    end
    if (LOAD_USE_CYCLES < 1 || LOAD_USE_CYCLES > 15) begin : g_bad_luc
        $error("pipeline_ctrl: LOAD_USE_CYCLES must be in 1..15");
    end

    // ------------------------------------------------------------------
    // Constant output patterns
    // ------------------------------------------------------------------
    localparam int DRAIN_W = $clog2(N_STAGES);

    localparam logic [MAX_STAGES-1:0] BR_SPAN = flush_span(BRANCH_FLUSH);
    localparam logic [MAX_STAGES-1:0] JP_SPAN = flush_span(JUMP_FLUSH);
    localparam logic [N_STAGES-1:0]   BR_MASK = BR_SPAN[N_STAGES-1:0];
    localparam logic [N_STAGES-1:0]   JP_MASK = JP_SPAN[N_STAGES-1:0];

    localparam logic [N_STAGES-1:0] ALL_EN    = '1;
    // Bubble: hold PC and IF/ID, inject a NOP into ID/EX, let the rest drain.
    localparam logic [N_STAGES-1:0] BUBBLE_EN = ALL_EN
                                              & ~(N_STAGES'(1) << STG_PC)
                                              & ~(N_STAGES'(1) << STG_IF_ID);
    localparam logic [N_STAGES-1:0] BUBBLE_FL = N_STAGES'(1) << STG_ID_EX;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]         state,     nxt_state;
    logic [3:0]         stall_cnt, nxt_stall;
    logic [DRAIN_W-1:0] drain_cnt, nxt_drain;
    logic [NB_CNT-1:0]  cycle_cnt;
    logic [NB_CNT-1:0]  stall_total;

    logic                advance;
    logic                load_use;
    logic                redirect;
    logic [N_STAGES-1:0] redirect_mask;
    logic                bubble;
    logic [N_STAGES-1:0] en_c;
    logic [N_STAGES-1:0] fl_c;

    load_use_detect #(
        .NB_REGS (NB_REGS)
    ) u_load_use (
        .i_id_rs       (i_id_rs),
        .i_id_rt       (i_id_rt),
        .i_id_uses_rt  (i_id_uses_rt),
        .i_ex_rt       (i_ex_rt),
        .i_ex_mem_read (i_ex_mem_read),
        .o_load_use    (load_use)
    );

    assign advance       = i_debug_mode ? i_step : 1'b1;
    assign redirect      = i_branch_taken || i_jump;
    // A branch resolves later than a jump, so its deeper squash wins.
    assign redirect_mask = i_branch_taken ? BR_MASK : JP_MASK;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        en_c      = '0;
        fl_c      = '0;
        bubble    = 1'b0;
        nxt_state = state;
        nxt_stall = stall_cnt;
        nxt_drain = drain_cnt;

        if (advance) begin
            case (state)
                ST_RUN: begin
                    if (redirect) begin
                        en_c = ALL_EN;
                        fl_c = redirect_mask;
                    end else if (load_use) begin
                        en_c   = BUBBLE_EN;
                        fl_c   = BUBBLE_FL;
                        bubble = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            nxt_state = ST_STALL;
                            nxt_stall = 4'(LOAD_USE_CYCLES - 1);
                        end
                    end else if (i_id_halt) begin
                        // Let the halt move into ID/EX, then stop fetching.
                        en_c      = ALL_EN;
                        nxt_state = ST_DRAIN;
                        nxt_drain = DRAIN_W'(N_STAGES - 2);
                    end else begin
                        en_c = ALL_EN;
                    end
                end

                ST_STALL: begin
                    if (redirect) begin
                        // The stalled reader is on the wrong path; drop it.
                        en_c      = ALL_EN;
                        fl_c      = redirect_mask;
                        nxt_state = ST_RUN;
                        nxt_stall = '0;
                    end else begin
                        en_c   = BUBBLE_EN;
                        fl_c   = BUBBLE_FL;
                        bubble = 1'b1;
                        if (stall_cnt <= 4'd1) begin
                            nxt_state = ST_RUN;
                            nxt_stall = '0;
                        end else begin
                            nxt_stall = stall_cnt - 4'd1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (redirect) begin
                        // The halt itself was speculative; resume normally.
                        en_c      = ALL_EN;
                        fl_c      = redirect_mask;
                        nxt_state = ST_RUN;
                        nxt_drain = '0;
                    end else begin
                        en_c = BUBBLE_EN;
                        fl_c = BUBBLE_FL;
                        if (drain_cnt <= DRAIN_W'(1)) begin
                            nxt_state = ST_HALTED;
                            nxt_drain = '0;
                        end else begin
                            nxt_drain = drain_cnt - DRAIN_W'(1);
                        end
                    end
                end

                default: begin
                    // HALTED: everything frozen until reset.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= ST_RUN;
            stall_cnt   <= '0;
            drain_cnt   <= '0;
            cycle_cnt   <= '0;
            stall_total <= '0;
        end else begin
            state     <= nxt_state;
            stall_cnt <= nxt_stall;
            drain_cnt <= nxt_drain;
            if (advance && state != ST_HALTED) begin
                cycle_cnt <= cycle_cnt + NB_CNT'(1);
            end
            if (bubble) begin
                stall_total <= stall_total + NB_CNT'(1);
            end
        end
    end

    // Combinational outputs are forced idle while reset is held so the
    // stage registers see no enables before the first clean edge.
    assign o_stage_en    = i_reset ? en_c : '0;
    assign o_flush       = i_reset ? fl_c : '0;
    assign o_state       = state;
    assign o_halted      = (state == ST_HALTED);
    assign o_cycle_count = cycle_cnt;
    assign o_stall_count = stall_total;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int N   = 5;
    localparam int NBR = 5;
    localparam int LUC = 2;
    localparam int BF  = 3;
    localparam int JF  = 2;
    localparam int NBC = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           dbg, stp;
    logic [NBR-1:0] id_rs, id_rt, ex_rt;
    logic           uses_rt, mem_rd, br, jp, halt;
    logic [N-1:0]   stage_en, flush;
    logic [1:0]     state;
    logic           halted;
    logic [NBC-1:0] cyc_cnt, stl_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .N_STAGES        (N),
        .NB_REGS         (NBR),
        .LOAD_USE_CYCLES (LUC),
        .BRANCH_FLUSH    (BF),
        .JUMP_FLUSH      (JF),
        .NB_CNT          (NBC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_debug_mode   (dbg),
        .i_step         (stp),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rt   (uses_rt),
        .i_ex_rt        (ex_rt),
        .i_ex_mem_read  (mem_rd),
        .i_branch_taken (br),
        .i_jump         (jp),
        .i_id_halt      (halt),
        .o_stage_en     (stage_en),
        .o_flush        (flush),
        .o_state        (state),
        .o_halted       (halted),
        .o_cycle_count  (cyc_cnt),
        .o_stall_count  (stl_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bubbles still owed, drain cycles still owed, halted flag.
    int             m_bub;
    int             m_drain;
    bit             m_halted;
    logic [NBC-1:0] m_cyc;
    logic [NBC-1:0] m_stl;

    function automatic logic [N-1:0] squash(input int depth);
        logic [N-1:0] m;
        m = '0;
        for (int i = 1; i <= depth; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_halted)     return 2'd3;
        if (m_drain > 0)  return 2'd2;
        if (m_bub > 0)    return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_bub = 0; m_drain = 0; m_halted = 0; m_cyc = '0; m_stl = '0;
    endtask

    task automatic idle_inputs();
        dbg = 0; stp = 0; id_rs = '0; id_rt = '0; ex_rt = '0;
        uses_rt = 0; mem_rd = 0; br = 0; jp = 0; halt = 0;
    endtask

    // Called just after a falling edge with inputs already driven: checks the
    // current cycle's outputs, advances the model, and waits for the next falling edge.
    task automatic tick();
        logic [N-1:0] een, efl, rmask;
        bit adv, lu, redir;
        #1;
        adv   = dbg ? stp : 1'b1;
        lu    = mem_rd && ex_rt != 0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
        redir = br || jp;
        rmask = br ? squash(BF) : squash(JF);
        check_val("state",  state,   model_state());
        check_val("halted", halted,  m_halted);
        check_val("cycles", cyc_cnt, m_cyc);
        check_val("stalls", stl_cnt, m_stl);
        een = '0;
        efl = '0;
        if (adv && !m_halted) begin
            m_cyc++;
            if (m_drain > 0 || m_bub > 0) begin
                if (redir) begin
                    een = '1; efl = rmask; m_drain = 0; m_bub = 0;
                end else begin
                    een = 5'b11100; efl = 5'b00100;
                    if (m_drain > 0) begin
                        m_drain--;
                        if (m_drain == 0) m_halted = 1;
                    end else begin
                        m_stl++;
                        m_bub--;
                    end
                end
            end else if (redir) begin
                een = '1; efl = rmask;
            end else if (lu) begin
                een = 5'b11100; efl = 5'b00100; m_stl++; m_bub = LUC - 1;
            end else if (halt) begin
                een = '1; m_drain = N - 2;
            end else begin
                een = '1;
            end
        end
        check_val("stage_en", stage_en, een);
        check_val("flush",    flush,    efl);
        @(negedge clk);
    endtask

    // Asserts reset part-way through a low phase and checks the asynchronous effect.
    task automatic apply_reset();
        #2;
        rst_n = 0;
        #1;
        check_val("rst_en",     stage_en, 0);
        check_val("rst_flush",  flush,    0);
        check_val("rst_state",  state,    0);
        check_val("rst_halted", halted,   0);
        check_val("rst_cycles", cyc_cnt,  0);
        check_val("rst_stalls", stl_cnt,  0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
    endtask

    logic [NBC-1:0] frozen;

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1;
        @(negedge clk);
        apply_reset();

        // Load-use: $t0 loaded in EX, read as rs in ID, two bubbles expected.
        mem_rd = 1; ex_rt = 5'd8; id_rs = 5'd8;
        tick();
        idle_inputs(); id_rs = 5'd8;
        tick();
        idle_inputs();
        tick();
        check_val("lu_stall_total", stl_cnt, 2);

        // Load to $zero read as rs=0: no hazard.
        mem_rd = 1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 check_val("zero_load_en", stage_en, 5'b11111);
        tick();
        idle_inputs();

        // Branch and jump together: branch depth wins.
        br = 1; jp = 1;
        #1 check_val("br_jp_flush", flush, 5'b01110);
        check_val("br_jp_en", stage_en, 5'b11111);
        tick();
        idle_inputs();

        // Halt in free run: accepted, three drain cycles, then halted.
        halt = 1;
        tick();
        idle_inputs();
        repeat (3) tick();
        check_val("halt_done", halted, 1);
        frozen = cyc_cnt;
        repeat (3) tick();
        check_val("halt_frozen", cyc_cnt, frozen);

        // Halt squashed by a branch in the second drain cycle.
        apply_reset();
        halt = 1;
        tick();
        idle_inputs();
        tick();
        br = 1;
        tick();
        idle_inputs();
        repeat (4) tick();
        check_val("squash_halted", halted, 0);
        check_val("squash_state",  state,  0);

        // Step mode: three single-cycle pulses across ten cycles.
        apply_reset();
        dbg = 1;
        for (int c = 0; c < 10; c++) begin
            stp = (c == 1 || c == 4 || c == 7);
            tick();
        end
        check_val("step_cycles", cyc_cnt, 3);
        idle_inputs();

        // Reset in the middle of a drain.
        apply_reset();
        halt = 1;
        tick();
        idle_inputs();
        tick();
        check_val("pre_rst_state", state, 2);
        apply_reset();
        tick();
        check_val("post_rst_state", state, 0);

        // Randomised segments, each starting from reset.
        for (int seg = 0; seg < 15; seg++) begin
            apply_reset();
            for (int c = 0; c < 80; c++) begin
                dbg     = (seg % 3 == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
                stp     = $urandom_range(0, 1);
                id_rs   = NBR'($urandom_range(0, 3));
                id_rt   = NBR'($urandom_range(0, 3));
                ex_rt   = NBR'($urandom_range(0, 3));
                uses_rt = $urandom_range(0, 1);
                mem_rd  = $urandom_range(0, 1);
                br      = ($urandom_range(0, 7) == 0);
                jp      = ($urandom_range(0, 7) == 0);
                halt    = ($urandom_range(0, 19) == 0);
                tick();
            end
            idle_inputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
